// File: rtl/seq_done_checker.sv
// rtl/seq_done_checker.sv - latency monitor for the phase-sequencer done level
module seq_done_checker #(
    parameter int CNT_W      = 8,
    parameter int EXP_MIN    = 37,
    parameter int EXP_MAX    = 37,
    parameter int TIMEOUT    = 200,
    parameter int BLINK_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_i,
    output logic [CNT_W-1:0] latency_o,
    output logic             valid_o,
    output logic             report_p_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic             drop_err_o,
    output logic             led_o
);

    typedef enum logic {
        WAIT   = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(EXP_MAX);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [BLINK_LOG2-1:0] blink;
    logic                  in_window;

    assign in_window = (cnt >= MIN_C) && (cnt <= MAX_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT;
            cnt        <= '0;
            blink      <= '0;
            latency_o  <= '0;
            valid_o    <= 1'b0;
            report_p_o <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
            drop_err_o <= 1'b0;
            led_o      <= 1'b0;
        end else begin
            report_p_o <= 1'b0;
            case (state)
                WAIT: begin
                    // Capture beats timeout when both happen on the same edge.
                    if (done_i) begin
                        latency_o  <= cnt;
                        valid_o    <= 1'b1;
                        report_p_o <= 1'b1;
                        pass_o     <= in_window;
                        fail_o     <= !in_window;
                        blink      <= '0;
                        led_o      <= 1'b1;
                        state      <= REPORT;
                    end else if (cnt == TMO_C) begin
                        latency_o  <= cnt;
                        timeout_o  <= 1'b1;
                        fail_o     <= 1'b1;
                        report_p_o <= 1'b1;
                        blink      <= '0;
                        led_o      <= 1'b1;
                        state      <= REPORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPORT: begin
                    blink <= blink + 1'b1;
                    if (valid_o && !done_i)
                        drop_err_o <= 1'b1;
                    if (pass_o && !drop_err_o)
                        led_o <= 1'b1;
                    else if (&blink)
                        led_o <= !led_o;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule
